log_dump_engine: RTL and testbench

Streams a window of the access-log BRAM (`bram_log` user port, 24-bit entries) out as a framed byte stream for the UART transmitter in `control_interface`. It sits between the log storage and the UART TX path. It issues one read at a time, splits each entry into bytes MSB-first, and wraps the dump in a header and an XOR checksum. It runs entirely in the 50 MHz control domain.

---
 rtl/log_dump_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_log_dump_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_dump_engine.sv
// log_dump_engine: streams a window of the access log as a framed byte
// stream (0xA5, 16-bit count, entry bytes MSB-first, XOR checksum) towards
// the UART transmitter. One log read is outstanding at a time.
module log_dump_engine #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic                  log_rd,
    input  logic [23:0]           log_data_in,
    input  logic                  log_data_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_SEND    = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Largest dump: the whole log, 2^ADDR_WIDTH entries.
    localparam logic [ADDR_WIDTH:0] MAX_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ZERO_CNT = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_CNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // XOR of the three bytes of one log entry (its checksum contribution).
    function automatic logic [7:0] entry_xor(input logic [23:0] d);
        entry_xor = d[23:16] ^ d[15:8] ^ d[7:0];
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            byte_idx_r, byte_idx_s;
    logic [ADDR_WIDTH:0]   cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic [ADDR_WIDTH:0]   entry_idx_r, entry_idx_s;
    logic [23:0]           data_r, data_s;
    logic [7:0]            csum_r, csum_s;

    logic                  busy_s, done_s, log_rd_s, tx_valid_s;
    logic [ADDR_WIDTH-1:0] log_addr_s;
    logic [7:0]            tx_data_s;

    logic                  xfer_s;
    logic [ADDR_WIDTH:0]   next_idx_s;
    logic [15:0]           cnt16_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_r  <= 2'd0;
            cnt_r       <= ZERO_CNT;
            base_r      <= {ADDR_WIDTH{1'b0}};
            entry_idx_r <= ZERO_CNT;
            data_r      <= 24'h000000;
            csum_r      <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            log_rd      <= 1'b0;
            log_addr    <= {ADDR_WIDTH{1'b0}};
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            byte_idx_r  <= byte_idx_s;
            cnt_r       <= cnt_s;
            base_r      <= base_s;
            entry_idx_r <= entry_idx_s;
            data_r      <= data_s;
            csum_r      <= csum_s;
            busy        <= busy_s;
            done        <= done_s;
            log_rd      <= log_rd_s;
            log_addr    <= log_addr_s;
            tx_valid    <= tx_valid_s;
            tx_data     <= tx_data_s;
        end
    end

    // Next-state and next-output logic; abort overrides everything else.
    always_comb begin
        state_s     = state_r;
        byte_idx_s  = byte_idx_r;
        cnt_s       = cnt_r;
        base_s      = base_r;
        entry_idx_s = entry_idx_r;
        data_s      = data_r;
        csum_s      = csum_r;
        busy_s      = busy;
        done_s      = 1'b0;
        log_rd_s    = 1'b0;
        log_addr_s  = log_addr;
        tx_valid_s  = tx_valid;
        tx_data_s   = tx_data;
        xfer_s      = tx_valid & tx_ready;
        next_idx_s  = entry_idx_r + ONE_CNT;
        cnt16_s     = 16'(cnt_r);

        if (abort) begin
            state_s    = ST_IDLE;
            busy_s     = 1'b0;
            tx_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s     = ST_HDR;
                        byte_idx_s  = 2'd0;
                        cnt_s       = (count > MAX_CNT) ? MAX_CNT : count;
                        base_s      = start_addr;
                        entry_idx_s = ZERO_CNT;
                        csum_s      = 8'h00;
                        busy_s      = 1'b1;
                        tx_valid_s  = 1'b1;
                        tx_data_s   = 8'hA5;
                    end else begin
                        busy_s     = 1'b0;
                        tx_valid_s = 1'b0;
                    end
                end
                ST_HDR: begin
                    if (xfer_s) begin
                        case (byte_idx_r)
                            2'd0: begin
                                tx_data_s  = cnt16_s[15:8];
                                byte_idx_s = 2'd1;
                            end
                            2'd1: begin
                                tx_data_s  = cnt16_s[7:0];
                                byte_idx_s = 2'd2;
                            end
                            default: begin
                                if (cnt_r == ZERO_CNT) begin
                                    state_s   = ST_CSUM;
                                    tx_data_s = csum_r;
                                end else begin
                                    state_s    = ST_RD_REQ;
                                    tx_valid_s = 1'b0;
                                    log_rd_s   = 1'b1;
                                    log_addr_s = base_r;
                                end
                            end
                        endcase
                    end else begin
                        state_s = ST_HDR;
                    end
                end
                ST_RD_REQ: begin
                    state_s = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (log_data_valid) begin
                        data_s     = log_data_in;
                        csum_s     = csum_r ^ entry_xor(log_data_in);
                        tx_valid_s = 1'b1;
                        tx_data_s  = log_data_in[23:16];
                        byte_idx_s = 2'd0;
                        state_s    = ST_SEND;
                    end else begin
                        state_s = ST_RD_WAIT;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        case (byte_idx_r)
                            2'd0: begin
                                tx_data_s  = data_r[15:8];
                                byte_idx_s = 2'd1;
                            end
                            2'd1: begin
                                tx_data_s  = data_r[7:0];
                                byte_idx_s = 2'd2;
                            end
                            default: begin
                                entry_idx_s = next_idx_s;
                                if (next_idx_s < cnt_r) begin
                                    state_s    = ST_RD_REQ;
                                    tx_valid_s = 1'b0;
                                    log_rd_s   = 1'b1;
                                    // Log address wraps modulo the log depth.
                                    log_addr_s = base_r + next_idx_s[ADDR_WIDTH-1:0];
                                end else begin
                                    state_s   = ST_CSUM;
                                    tx_data_s = csum_r;
                                end
                            end
                        endcase
                    end else begin
                        state_s = ST_SEND;
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        state_s    = ST_DONE;
                        tx_valid_s = 1'b0;
                        done_s     = 1'b1;
                        busy_s     = 1'b0;
                    end else begin
                        state_s = ST_CSUM;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s    = ST_IDLE;
                    busy_s     = 1'b0;
                    tx_valid_s = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log_dump_engine.sv
// Directed self-checking bench for log_dump_engine: a behavioural log
// memory answers reads after a chosen latency, and the UART side is
// modelled by a tx_ready pattern while transferred bytes are collected.
module tb_log_dump_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  start_addr;
    logic [10:0] count;
    logic        busy;
    logic        done;
    logic [9:0]  log_addr;
    logic        log_rd;
    logic [23:0] log_data_in;
    logic        log_data_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    log_dump_engine #(.ADDR_WIDTH(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .start_addr     (start_addr),
        .count          (count),
        .busy           (busy),
        .done           (done),
        .log_addr       (log_addr),
        .log_rd         (log_rd),
        .log_data_in    (log_data_in),
        .log_data_valid (log_data_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [1024];
    logic [7:0]  mem_b;
    logic [7:0]  exp_two [10];
    logic [7:0]  exp_zero [4];

    logic [7:0]  byte_q [$];
    int          addr_q [$];
    int          rd_cnt;
    int          done_cnt;
    int          stall_err;
    int          addr_err;
    bit          timed_out;

    // Drive a one-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic pulse_start(input logic [9:0] a, input logic [10:0] c);
        start_addr = a;
        count      = c;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Run the frame: sample outputs at negedges, drive tx_ready and the log
    // model, collect bytes/reads; stops 3 cycles after done or at max_cyc.
    task automatic run_frame(input int max_cyc, input int rdy_period,
                             input int lat, input int start_at);
        int         cyc;
        int         post;
        bit         seen_done;
        bit         pend;
        int         wait_cnt;
        logic [9:0] rd_addr;
        bit         have_held;
        logic [7:0] held;
        byte_q.delete();
        addr_q.delete();
        rd_cnt = 0; done_cnt = 0; stall_err = 0; addr_err = 0;
        cyc = 0; post = 0; seen_done = 0; pend = 0; wait_cnt = 0;
        rd_addr = 10'd0; have_held = 0; held = 8'h00;
        while (cyc < max_cyc && post < 3) begin
            if (done) begin
                done_cnt++;
                seen_done = 1;
            end
            if (have_held) begin
                if (tx_valid !== 1'b1 || tx_data !== held) stall_err++;
                have_held = 0;
            end
            if (pend && log_addr !== rd_addr) addr_err++;
            tx_ready = (rdy_period <= 1) ? 1'b1 : ((cyc % rdy_period) == (rdy_period - 1));
            if (tx_valid && tx_ready) begin
                byte_q.push_back(tx_data);
            end else if (tx_valid) begin
                have_held = 1;
                held      = tx_data;
            end
            log_data_valid = 1'b0;
            if (pend) begin
                wait_cnt--;
                if (wait_cnt <= 0) begin
                    log_data_valid = 1'b1;
                    log_data_in    = mem[rd_addr];
                    pend           = 0;
                end
            end
            if (log_rd) begin
                rd_cnt++;
                addr_q.push_back(int'(log_addr));
                rd_addr  = log_addr;
                pend     = 1;
                wait_cnt = lat;
            end
            start = (cyc == start_at);
            if (cyc == start_at) begin
                start_addr = 10'd7;
                count      = 11'd1;
            end
            if (seen_done) post++;
            cyc++;
            @(negedge clk);
        end
        timed_out      = !seen_done;
        log_data_valid = 1'b0;
        start          = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (log_rd !== 1'b0) begin errors++; $display("FAIL reset_log_rd: got %b expected 0", log_rd); end
        checks++; if (log_addr !== 10'd0) begin errors++; $display("FAIL reset_log_addr: got %0d expected 0", log_addr); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h expected 00", tx_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tx_ready = 1'b1;
        pulse_start(10'd5, 11'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL basic_first_byte: got valid=%b data=%02h expected valid=1 data=a5", tx_valid, tx_data); end
        run_frame(200, 1, 2, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (byte_q.size() != 10) begin errors++; $display("FAIL basic_len: got %0d expected 10", byte_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < byte_q.size()) begin
                checks++;
                if (byte_q[i] !== exp_two[i]) begin errors++; $display("FAIL basic_byte[%0d]: got %02h expected %02h", i, byte_q[i], exp_two[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (rd_cnt != 2) begin errors++; $display("FAIL basic_rd_cnt: got %0d expected 2", rd_cnt); end
        if (addr_q.size() >= 2) begin
            checks++; if (addr_q[0] != 5) begin errors++; $display("FAIL basic_addr0: got %0d expected 5", addr_q[0]); end
            checks++; if (addr_q[1] != 6) begin errors++; $display("FAIL basic_addr1: got %0d expected 6", addr_q[1]); end
        end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL basic_addr_stable: got %0d changes expected 0", addr_err); end
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy=%b valid=%b expected 0 0", busy, tx_valid); end
    endtask

    task automatic test_zero_count();
        tx_ready = 1'b1;
        pulse_start(10'd9, 11'd0);
        run_frame(50, 1, 1, -1);
        checks++; if (byte_q.size() != 4) begin errors++; $display("FAIL zero_len: got %0d expected 4", byte_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < byte_q.size()) begin
                checks++;
                if (byte_q[i] !== exp_zero[i]) begin errors++; $display("FAIL zero_byte[%0d]: got %02h expected %02h", i, byte_q[i], exp_zero[i]); end
            end
        end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL zero_rd_cnt: got %0d expected 0", rd_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_stall();
        tx_ready = 1'b0;
        pulse_start(10'd5, 11'd2);
        run_frame(400, 3, 2, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++; if (byte_q.size() != 10) begin errors++; $display("FAIL stall_len: got %0d expected 10", byte_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < byte_q.size()) begin
                checks++;
                if (byte_q[i] !== exp_two[i]) begin errors++; $display("FAIL stall_byte[%0d]: got %02h expected %02h", i, byte_q[i], exp_two[i]); end
            end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_clamp_wrap();
        tx_ready = 1'b1;
        pulse_start(10'd1023, 11'd2047);
        run_frame(30, 1, 1, 10);
        checks++; if (byte_q.size() < 6) begin errors++; $display("FAIL clamp_len: got %0d expected at least 6", byte_q.size()); end
        if (byte_q.size() >= 6) begin
            checks++; if (byte_q[0] !== 8'hA5) begin errors++; $display("FAIL clamp_sync: got %02h expected a5", byte_q[0]); end
            checks++; if (byte_q[1] !== 8'h04) begin errors++; $display("FAIL clamp_cnt_hi: got %02h expected 04", byte_q[1]); end
            checks++; if (byte_q[2] !== 8'h00) begin errors++; $display("FAIL clamp_cnt_lo: got %02h expected 00", byte_q[2]); end
            checks++; if (byte_q[3] !== 8'hFF || byte_q[4] !== 8'hA5 || byte_q[5] !== 8'h00) begin errors++; $display("FAIL clamp_entry1023: got %02h %02h %02h expected ff a5 00", byte_q[3], byte_q[4], byte_q[5]); end
        end
        checks++; if (addr_q.size() < 4) begin errors++; $display("FAIL clamp_rd_cnt: got %0d expected at least 4", addr_q.size()); end
        if (addr_q.size() >= 4) begin
            checks++; if (addr_q[0] != 1023 || addr_q[1] != 0 || addr_q[2] != 1 || addr_q[3] != 2) begin errors++; $display("FAIL clamp_addr_seq: got %0d %0d %0d %0d expected 1023 0 1 2", addr_q[0], addr_q[1], addr_q[2], addr_q[3]); end
        end
        checks++; if (done_cnt != 0 || busy !== 1'b1) begin errors++; $display("FAIL clamp_still_busy: got done_cnt=%0d busy=%b expected 0 1", done_cnt, busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL clamp_abort: got busy=%b valid=%b expected 0 0", busy, tx_valid); end
    endtask

    task automatic test_abort();
        tx_ready = 1'b1;
        pulse_start(10'd5, 11'd2);
        for (int i = 0; i < 20 && log_rd !== 1'b1; i++) @(negedge clk);
        checks++; if (log_rd !== 1'b1) begin errors++; $display("FAIL abort_no_read: got %b expected 1", log_rd); end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || log_rd !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_outputs: got busy=%b valid=%b rd=%b done=%b expected 0 0 0 0", busy, tx_valid, log_rd, done); end
        log_data_in    = 24'h777777;
        log_data_valid = 1'b1;
        @(negedge clk);
        log_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_late_data[%0d]: got valid=%b done=%b busy=%b expected 0 0 0", i, tx_valid, done, busy); end
            @(negedge clk);
        end
        pulse_start(10'd9, 11'd0);
        run_frame(50, 1, 1, -1);
        checks++; if (byte_q.size() != 4) begin errors++; $display("FAIL abort_restart_len: got %0d expected 4", byte_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < byte_q.size()) begin
                checks++;
                if (byte_q[i] !== exp_zero[i]) begin errors++; $display("FAIL abort_restart_byte[%0d]: got %02h expected %02h", i, byte_q[i], exp_zero[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_restart_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        pulse_start(10'd5, 11'd2);
        run_frame(6, 1, 1, -1);
        tx_ready = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h34) begin errors++; $display("FAIL rstmid_pre: got valid=%b busy=%b data=%02h expected 1 1 34", tx_valid, busy, tx_data); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || log_rd !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b done=%b rd=%b expected 0 0 0", busy, done, log_rd); end
        checks++; if (log_addr !== 10'd0 || tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got addr=%0d valid=%b data=%02h expected 0 0 00", log_addr, tx_valid, tx_data); end
        @(negedge clk);
        tx_ready = 1'b1;
        pulse_start(10'd5, 11'd2);
        run_frame(200, 1, 2, -1);
        checks++; if (byte_q.size() != 10) begin errors++; $display("FAIL rstmid_len: got %0d expected 10", byte_q.size()); end
        for (int i = 0; i < 10; i++) begin
            if (i < byte_q.size()) begin
                checks++;
                if (byte_q[i] !== exp_two[i]) begin errors++; $display("FAIL rstmid_byte[%0d]: got %02h expected %02h", i, byte_q[i], exp_two[i]); end
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        start_addr     = 10'd0;
        count          = 11'd0;
        log_data_in    = 24'h000000;
        log_data_valid = 1'b0;
        tx_ready       = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem_b  = 8'(i);
            mem[i] = {mem_b, mem_b ^ 8'h5A, ~mem_b};
        end
        mem[5] = 24'h123456;
        mem[6] = 24'hABCDEF;
        // Checksum = 12^34^56^AB^CD^EF = F9 (header excluded).
        exp_two  = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9};
        exp_zero = '{8'hA5, 8'h00, 8'h00, 8'h00};

        test_reset();
        test_basic();
        test_zero_count();
        test_stall();
        test_clamp_wrap();
        test_abort();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
